// File: rtl/lfsr_bank_if.sv
// Seed-load request channel and sample-stream channel of the lfsr_bank.
// The bank itself uses the slave modport; a consumer or driver uses master.
interface lfsr_bank_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      seed_valid;
  logic                      seed_ready;
  logic [CW-1:0]             seed_chan;
  logic [WIDTH-1:0]          seed_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;

  modport master (
    output seed_valid, seed_chan, seed_data, out_ready,
    input  seed_ready, out_valid, out_data
  );

  modport slave (
    input  seed_valid, seed_chan, seed_data, out_ready,
    output seed_ready, out_valid, out_data
  );
endinterface

// File: rtl/lfsr_bank.sv
// Bank of independent XNOR Fibonacci LFSRs feeding p-bit update logic, with
// per-channel reseeding, all-ones lock-up protection and a warm-up phase.
module lfsr_bank #(
  parameter int               WIDTH        = 32,
  parameter int               CHANNELS     = 4,
  parameter logic [WIDTH-1:0] TAPS         = 32'h8020_0003,
  parameter int               STEP         = 1,
  parameter int               WARMUP       = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h0000_0001
) (
  input logic        clk,
  input logic        reset_n,
  lfsr_bank_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {ST_WARMUP, ST_RUN} state_t;
  localparam state_t RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  state_t           r_state;
  logic [7:0]       r_count;
  logic [WIDTH-1:0] r_chan [CHANNELS];

  logic          w_outFire;
  logic          w_seedFire;
  logic          w_seedHit;
  logic [CW:0]   w_chanExt;

  // All-ones is the XNOR lock-up state, so it is nudged off by clearing bit 0.
  function automatic logic [WIDTH-1:0] fixSeed(input logic [WIDTH-1:0] s);
    return (&s) ? {s[WIDTH-1:1], 1'b0} : s;
  endfunction

  function automatic logic [WIDTH-1:0] resetSeed(input int idx);
    logic [WIDTH-1:0] v;
    v = DEFAULT_SEED + WIDTH'(idx);
    return fixSeed(v);
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] v;
    logic             fb;
    v = s;
    for (int k = 0; k < STEP; k++) begin
      fb = ~^(v & TAPS);
      v  = {v[WIDTH-2:0], fb};
    end
    return v;
  endfunction

  assign w_chanExt  = {1'b0, bus.seed_chan};
  assign w_outFire  = (r_state == ST_RUN) && bus.out_ready;
  assign w_seedFire = (r_state == ST_RUN) && bus.seed_valid;
  assign w_seedHit  = w_seedFire && (w_chanExt < (CW+1)'(CHANNELS));

  assign bus.out_valid  = (r_state == ST_RUN);
  assign bus.seed_ready = (r_state == ST_RUN);

  for (genvar g = 0; g < CHANNELS; g++) begin : gOut
    assign bus.out_data[g*WIDTH +: WIDTH] = r_chan[g];
  end

  // Warm-up free-runs every channel; in RUN a channel moves only on an output
  // handshake, except the addressed channel of an accepted seed which loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RESET_STATE;
      r_count <= 8'(WARMUP);
      for (int i = 0; i < CHANNELS; i++) begin
        r_chan[i] <= resetSeed(i);
      end
    end else begin
      case (r_state)
        ST_WARMUP: begin
          for (int i = 0; i < CHANNELS; i++) begin
            r_chan[i] <= advance(r_chan[i]);
          end
          r_count <= r_count - 8'd1;
          if (r_count <= 8'd1) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (w_seedHit && (w_chanExt == (CW+1)'(i))) begin
              r_chan[i] <= fixSeed(bus.seed_data);
            end else if (w_outFire) begin
              r_chan[i] <= advance(r_chan[i]);
            end
          end
          if (w_seedHit && (WARMUP != 0)) begin
            r_state <= ST_WARMUP;
            r_count <= 8'(WARMUP);
          end
        end
        default: begin
          r_state <= RESET_STATE;
          r_count <= 8'(WARMUP);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_bank.sv
// Directed bench for lfsr_bank: four instances cover single/multi-step,
// warm-up and back-pressure, lock-up, simultaneous events and 8-bit period.
module tb_lfsr_bank;
  localparam logic [63:0] TAP32 = 64'h8020_0003;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] modelA [4];
  logic [63:0] modelC [3];
  int   firstRet [4];
  int   lows;
  int   ones;

  always #5 clk = ~clk;

  lfsr_bank_if #(.WIDTH(32), .CHANNELS(4)) ifA ();
  lfsr_bank_if #(.WIDTH(32), .CHANNELS(4)) ifB ();
  lfsr_bank_if #(.WIDTH(32), .CHANNELS(3)) ifC ();
  lfsr_bank_if #(.WIDTH(8),  .CHANNELS(4)) ifD ();

  lfsr_bank #(.WIDTH(32), .CHANNELS(4), .STEP(1), .WARMUP(0)) dutA (
    .clk(clk), .reset_n(reset_n), .bus(ifA.slave));
  lfsr_bank #(.WIDTH(32), .CHANNELS(4), .STEP(3), .WARMUP(0)) dutB (
    .clk(clk), .reset_n(reset_n), .bus(ifB.slave));
  lfsr_bank #(.WIDTH(32), .CHANNELS(3), .STEP(1), .WARMUP(16)) dutC (
    .clk(clk), .reset_n(reset_n), .bus(ifC.slave));
  lfsr_bank #(.WIDTH(8), .CHANNELS(4), .TAPS(8'hB8), .STEP(1), .WARMUP(0),
              .DEFAULT_SEED(8'h01)) dutD (
    .clk(clk), .reset_n(reset_n), .bus(ifD.slave));

  function automatic logic [63:0] lfsrAdv(input logic [63:0] s, input int w,
                                          input logic [63:0] taps, input int n);
    logic [63:0] v;
    logic        fb;
    v = s;
    for (int k = 0; k < n; k++) begin
      fb = ~^(v & taps);
      v  = ((v << 1) | {63'd0, fb}) & ((64'd1 << w) - 64'd1);
    end
    return v;
  endfunction

  function automatic logic [31:0] chA(input int i); return ifA.out_data[i*32 +: 32]; endfunction
  function automatic logic [31:0] chB(input int i); return ifB.out_data[i*32 +: 32]; endfunction
  function automatic logic [31:0] chC(input int i); return ifC.out_data[i*32 +: 32]; endfunction
  function automatic logic [7:0]  chD(input int i); return ifD.out_data[i*8 +: 8];   endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic advanceModelA();
    for (int i = 0; i < 4; i++) modelA[i] = lfsrAdv(modelA[i], 32, TAP32, 1);
  endtask

  task automatic checkAllA(input string tag);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("%s_ch%0d", tag, i), chA(i), modelA[i]);
  endtask

  task automatic checkAllC(input string tag);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("%s_ch%0d", tag, i), chC(i), modelC[i]);
  endtask

  initial begin
    ifA.seed_valid = 0; ifA.seed_chan = '0; ifA.seed_data = '0; ifA.out_ready = 0;
    ifB.seed_valid = 0; ifB.seed_chan = '0; ifB.seed_data = '0; ifB.out_ready = 0;
    ifC.seed_valid = 0; ifC.seed_chan = '0; ifC.seed_data = '0; ifC.out_ready = 0;
    ifD.seed_valid = 0; ifD.seed_chan = '0; ifD.seed_data = '0; ifD.out_ready = 0;
    reset_n = 1'b0;
    #12;

    checkOutput("rstC_valid", ifC.out_valid, 0);
    checkOutput("rstC_sready", ifC.seed_ready, 0);
    checkOutput("rstA_valid", ifA.out_valid, 1);
    checkOutput("rstA_sready", ifA.seed_ready, 1);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("rstC_ch%0d", i), chC(i), 64'(i + 1));
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) modelA[i] = 64'(i + 1);
    for (int i = 0; i < 3; i++) modelC[i] = lfsrAdv(64'(i + 1), 32, TAP32, 16);

    // Warm-up: first valid sample exactly 16 cycles after reset release.
    applyStimulus(15);
    checkOutput("warm15_valid", ifC.out_valid, 0);
    applyStimulus(1);
    checkOutput("warm16_valid", ifC.out_valid, 1);
    checkOutput("warm16_sready", ifC.seed_ready, 1);
    checkAllC("warm16");

    // Seed 1 into channel 0 of A (STEP=1) and B (STEP=3) with streaming.
    ifA.seed_valid = 1; ifA.seed_chan = 2'd0; ifA.seed_data = 32'h1; ifA.out_ready = 1;
    ifB.seed_valid = 1; ifB.seed_chan = 2'd0; ifB.seed_data = 32'h1; ifB.out_ready = 1;
    applyStimulus(1);
    ifA.seed_valid = 0; ifB.seed_valid = 0;
    advanceModelA();
    modelA[0] = 64'h1;
    checkAllA("seedA");
    checkOutput("stepB_0", chB(0), 64'h1);
    applyStimulus(1);
    advanceModelA();
    checkOutput("stepA_1", chA(0), 64'h2);
    checkOutput("stepB_1", chB(0), 64'h9);
    applyStimulus(1);
    advanceModelA();
    checkOutput("stepA_2", chA(0), 64'h4);
    applyStimulus(1);
    advanceModelA();
    checkOutput("stepA_3", chA(0), 64'h9);
    checkAllA("stepA_3");
    ifA.out_ready = 0; ifB.out_ready = 0;

    // Output handshake and seed load to channel 1 in the same cycle.
    checkOutput("simA_valid", ifA.out_valid, 1);
    ifA.out_ready = 1; ifA.seed_valid = 1; ifA.seed_chan = 2'd1; ifA.seed_data = 32'hFFFF_FFFF;
    applyStimulus(1);
    ifA.out_ready = 0; ifA.seed_valid = 0;
    advanceModelA();
    modelA[1] = 64'hFFFF_FFFE;
    checkAllA("simA");

    // Lock-up: all-ones seed into channel 2, then stream for a while.
    ifA.seed_valid = 1; ifA.seed_chan = 2'd2; ifA.seed_data = 32'hFFFF_FFFF;
    applyStimulus(1);
    ifA.seed_valid = 0;
    modelA[2] = 64'hFFFF_FFFE;
    checkAllA("lockA");
    ifA.out_ready = 1;
    ones = 0;
    for (int k = 0; k < 2000; k++) begin
      applyStimulus(1);
      advanceModelA();
      if (chA(2) == 32'hFFFF_FFFF) ones++;
    end
    ifA.out_ready = 0;
    checkOutput("lockA_allones", 64'(ones), 0);
    checkAllA("lockA_run");

    // Back-pressure: output held stable and valid with out_ready low.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1);
      checkOutput("bpC_valid", ifC.out_valid, 1);
      checkAllC("bpC");
    end

    // Throughput: one new sample per cycle while out_ready is high.
    ifC.out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      for (int i = 0; i < 3; i++) modelC[i] = lfsrAdv(modelC[i], 32, TAP32, 1);
      checkOutput("tputC_valid", ifC.out_valid, 1);
      checkAllC("tputC");
    end
    ifC.out_ready = 0;

    // Reseed with WARMUP=16: valid and seed_ready low for exactly 16 cycles.
    ifC.seed_valid = 1; ifC.seed_chan = 2'd0; ifC.seed_data = 32'h1234_5678;
    applyStimulus(1);
    ifC.seed_valid = 0;
    lows = 0;
    for (int k = 0; k < 16; k++) begin
      if (!ifC.out_valid && !ifC.seed_ready) lows++;
      applyStimulus(1);
    end
    checkOutput("reseedC_lows", 64'(lows), 16);
    checkOutput("reseedC_valid", ifC.out_valid, 1);
    modelC[0] = lfsrAdv(64'h1234_5678, 32, TAP32, 16);
    for (int i = 1; i < 3; i++) modelC[i] = lfsrAdv(modelC[i], 32, TAP32, 16);
    checkAllC("reseedC");

    // Out-of-range channel: accepted, discarded, no warm-up restart.
    ifC.seed_valid = 1; ifC.seed_chan = 2'd3; ifC.seed_data = 32'h0000_DEAD;
    applyStimulus(1);
    ifC.seed_valid = 0;
    checkOutput("badchC_valid", ifC.out_valid, 1);
    applyStimulus(1);
    checkOutput("badchC_valid2", ifC.out_valid, 1);
    checkOutput("badchC_sready", ifC.seed_ready, 1);
    checkAllC("badchC");

    // Period of every 8-bit channel with a maximal tap mask.
    for (int i = 0; i < 4; i++) firstRet[i] = 0;
    ifD.out_ready = 1;
    for (int s = 1; s <= 300; s++) begin
      applyStimulus(1);
      for (int i = 0; i < 4; i++) begin
        if (firstRet[i] == 0 && chD(i) == 8'(i + 1)) firstRet[i] = s;
      end
    end
    for (int i = 0; i < 4; i++) checkOutput($sformatf("periodD_ch%0d", i), 64'(firstRet[i]), 255);

    // Asynchronous reset mid-stream restores reset seeds at once.
    ifA.out_ready = 1;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("midrstD_ch%0d", i), chD(i), 64'(i + 1));
      checkOutput($sformatf("midrstA_ch%0d", i), chA(i), 64'(i + 1));
    end
    checkOutput("midrstC_valid", ifC.out_valid, 0);
    checkOutput("midrstC_ch0", chC(0), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
